uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: FIFO depth in bytes; SHALL be a power of two in the range 2..256.
REQ-002 Parameter AW, default $clog2(DEPTH): pointer width; SHALL be derived from DEPTH and never overridden.
REQ-003 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cs_n  input  1  bus chip select, active-low.
REQ-006 we  input  1  bus write strobe; qualified by cs_n=0.
REQ-007 addr  input  2  register select: 00 DATA, 01 STATUS, 10 COUNT, 11 CTRL.
REQ-008 wdata  input  8  bus write data.
REQ-009 rdata  output  8  bus read data, combinational.
REQ-010 tx_data  output  8  byte offered to the transmitter.
REQ-011 tx_valid  output  1  tx_data is valid.
REQ-012 tx_ready  input  1  transmitter is idle and accepts a byte this cycle.

Function
REQ-013 Push: cs_n=0, we=1, addr=00 and FIFO not full SHALL write wdata to mem[wptr]; wptr and count SHALL increment on the same edge.
REQ-014 A push while full SHALL be dropped; memory, wptr and count SHALL be unchanged, even if a pop occurs in the same cycle.
REQ-015 tx_valid SHALL equal (count != 0); tx_data SHALL equal mem[rptr] (show-ahead, zero latency).
REQ-016 Pop: tx_valid=1 and tx_ready=1 SHALL increment rptr and decrement count on that edge.
REQ-017 A simultaneous accepted push and pop SHALL leave count unchanged and advance both pointers.
REQ-018 wptr and rptr SHALL wrap from DEPTH-1 to 0 (modulo-DEPTH, AW bits); count SHALL be AW+1 bits, range 0..DEPTH.
REQ-019 Flush: cs_n=0, we=1, addr=11, wdata[0]=1 SHALL clear wptr, rptr and count on that edge; flush SHALL take priority over a push or pop in the same cycle.
REQ-020 Read with cs_n=0, we=0: addr 00 -> 8'h00; 01 -> {5'b0, ovf, full, empty}; 10 -> count zero-extended to 8 bits (DEPTH=256 full reports 8'h00 with full=1); 11 -> 8'h00.
REQ-021 rdata SHALL be 8'h00 when cs_n=1 or we=1.
REQ-022 empty = (count==0); full = (count==DEPTH).
REQ-023 Writes to addr 01 and 10 SHALL have no effect.

Reset
REQ-024 rst_n=0 SHALL immediately clear wptr, rptr, count and ovf; tx_valid SHALL be 0, tx_data undefined-but-stable is not allowed: tx_data SHALL read mem[0].
REQ-025 Memory contents SHALL NOT require reset.
REQ-026 Reset asserted mid-operation SHALL discard all queued bytes; first cycle after release SHALL show empty=1, tx_valid=0.

Configuration
REQ-027 Macro UART_TXF_OVF_EN defined: ovf SHALL be a sticky register set by any dropped push (REQ-014), cleared by a STATUS read (cs_n=0, we=0, addr=01) or flush; set SHALL win over clear in the same cycle.
REQ-028 Macro UART_TXF_OVF_EN undefined: no ovf register SHALL exist; STATUS bit 2 SHALL read 0.

Verification
REQ-029 Reset, write 8'hA5 to DATA, tx_ready=0 -> next cycle tx_valid=1, tx_data=8'hA5, COUNT reads 8'h01, STATUS reads 8'h00.
REQ-030 Push 16 bytes 8'h00..8'h0F with tx_ready=0 -> STATUS 8'h02, COUNT 8'h10; 17th push 8'hFF dropped; with macro STATUS 8'h06, then reads 8'h02.
REQ-031 From full, hold tx_ready=1 for 16 cycles -> tx_data sequence 8'h00..8'h0F, then tx_valid=0, STATUS 8'h01; pointers wrapped to 0.
REQ-032 count=3, same cycle push 8'h55 and pop -> count stays 3; 8'h55 emerges after the 3 prior bytes.
REQ-033 count=5, flush with simultaneous push and tx_ready=1 -> next cycle count=0, tx_valid=0, ovf=0.
REQ-034 count=4, assert rst_n=0 for 1 cycle mid-pop -> tx_valid drops asynchronously; after release COUNT 8'h00, STATUS 8'h01.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Bus-programmed byte FIFO feeding a UART transmitter, show-ahead
//            output. Define UART_TXF_OVF_EN for the sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cs_n,
    input  logic       we,
    input  logic [1:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready
);

    localparam logic [1:0]  c_ADDR_DATA   = 2'b00;
    localparam logic [1:0]  c_ADDR_STATUS = 2'b01;
    localparam logic [1:0]  c_ADDR_COUNT  = 2'b10;
    localparam logic [1:0]  c_ADDR_CTRL   = 2'b11;
    localparam logic [AW:0] c_FULL_COUNT  = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic       w_empty;
    logic       w_full;
    logic       w_push_req;
    logic       w_push;
    logic       w_pop;
    logic       w_flush;
    logic       w_ovf;
    logic [7:0] w_count_byte;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_FULL_COUNT);
    assign w_push_req = !cs_n && we && (addr == c_ADDR_DATA);
    assign w_push     = w_push_req && !w_full;
    assign w_pop      = tx_valid && tx_ready;
    assign w_flush    = !cs_n && we && (addr == c_ADDR_CTRL) && wdata[0];

    assign tx_valid = !w_empty;
    assign tx_data  = r_mem[r_rptr];

    // With DEPTH=256 a full FIFO truncates to 8'h00; STATUS.full disambiguates.
    assign w_count_byte = 8'(r_count);

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef UART_TXF_OVF_EN
    logic r_ovf;
    logic w_drop;
    logic w_status_rd;

    assign w_drop      = w_push_req && w_full;
    assign w_status_rd = !cs_n && !we && (addr == c_ADDR_STATUS);

    // A drop in the same cycle as a clear must not be lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (w_status_rd || w_flush) begin
            r_ovf <= 1'b0;
        end
    end

    assign w_ovf = r_ovf;
`else
    assign w_ovf = 1'b0;
`endif

    always_comb begin
        rdata = 8'h00;
        if (!cs_n && !we) begin
            case (addr)
                c_ADDR_STATUS: rdata = {5'b00000, w_ovf, w_full, w_empty};
                c_ADDR_COUNT:  rdata = w_count_byte;
                default:       rdata = 8'h00;
            endcase
        end
    end

    a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
        r_count <= c_FULL_COUNT);

    a_ptr_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        (r_wptr - r_rptr) == r_count[AW-1:0]);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo against a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cs_n;
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    int tests = 0;
    int fails = 0;

    // Reference model: the FIFO is a queue, the storage a plain array.
    logic [7:0] m_q[$];
    bit         m_ovf = 1'b0;
    logic [7:0] m_mem [DEPTH];
    int         m_wpos = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cs_n     (cs_n),
        .we       (we),
        .addr     (addr),
        .wdata    (wdata),
        .rdata    (rdata),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    function automatic logic [7:0] exp_rdata();
        if (cs_n || we) return 8'h00;
        case (addr)
            2'd1:    return {5'b00000, m_ovf, m_q.size() == DEPTH, m_q.size() == 0};
            2'd2:    return 8'(m_q.size());
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_wpos = 0;
    endfunction

    // Advance one clock edge, applying the current inputs to the model.
    task automatic step();
        bit         push_req;
        bit         flush;
        bit         pop;
        bit         full;
        logic [7:0] d;
        push_req = !cs_n && we && (addr == 2'd0);
        flush    = !cs_n && we && (addr == 2'd3) && wdata[0];
        pop      = (m_q.size() != 0) && tx_ready;
        full     = (m_q.size() == DEPTH);
        d        = wdata;
`ifdef UART_TXF_OVF_EN
        begin
            bit status_rd;
            status_rd = !cs_n && !we && (addr == 2'd1);
            if (push_req && full) m_ovf = 1'b1;
            else if (status_rd || flush) m_ovf = 1'b0;
        end
`endif
        @(posedge clk);
        #1;
        if (flush) begin
            m_q.delete();
            m_wpos = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (push_req && !full) begin
                m_q.push_back(d);
                m_mem[m_wpos] = d;
                m_wpos = (m_wpos + 1) % DEPTH;
            end
        end
    endtask

    task automatic idle();
        cs_n  = 1'b1;
        we    = 1'b0;
        addr  = 2'd0;
        wdata = 8'h00;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [7:0] d);
        cs_n = 1'b0; we = 1'b1; addr = a; wdata = d;
        step();
        idle();
    endtask

    task automatic do_push(input logic [7:0] d);
        do_write(2'd0, d);
    endtask

    task automatic do_read(input logic [1:0] a, output logic [7:0] v);
        cs_n = 1'b0; we = 1'b0; addr = a;
        #1;
        v = rdata;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n = 1'b0; tx_ready = 1'b0; idle();
        repeat (2) @(posedge clk);
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_valid); end
        cs_n = 1'b0; we = 1'b0; addr = 2'd1; #1;
        tests++; if (rdata !== 8'h01) begin fails++; $display("FAIL reset_status_held: got %h expected 01", rdata); end
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        do_read(2'd2, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL reset_count: got %h expected 00", v); end
    endtask

    task automatic test_single_push();
        logic [7:0] v;
        tx_ready = 1'b0;
        do_push(8'hA5);
        tests++; if (tx_valid !== 1'b1) begin fails++; $display("FAIL single_tx_valid: got %b expected 1", tx_valid); end
        tests++; if (tx_data !== 8'hA5) begin fails++; $display("FAIL single_tx_data: got %h expected a5", tx_data); end
        do_read(2'd2, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL single_count: got %h expected 01", v); end
        do_read(2'd1, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL single_status: got %h expected 00", v); end
        do_write(2'd3, 8'h01);
    endtask

    task automatic test_fill_overflow();
        logic [7:0] v;
        logic [7:0] exp_ovf_status;
`ifdef UART_TXF_OVF_EN
        exp_ovf_status = 8'h06;
`else
        exp_ovf_status = 8'h02;
`endif
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_push(8'(i));
        do_read(2'd1, v);
        tests++; if (v !== 8'h02) begin fails++; $display("FAIL full_status: got %h expected 02", v); end
        do_read(2'd2, v);
        tests++; if (v !== 8'h10) begin fails++; $display("FAIL full_count: got %h expected 10", v); end
        do_push(8'hFF);
        do_read(2'd1, v);
        tests++; if (v !== exp_ovf_status) begin fails++; $display("FAIL drop_status: got %h expected %h", v, exp_ovf_status); end
        do_read(2'd1, v);
        tests++; if (v !== 8'h02) begin fails++; $display("FAIL status_reread: got %h expected 02", v); end
        tests++; if (tx_data !== 8'h00) begin fails++; $display("FAIL drop_head: got %h expected 00", tx_data); end
    endtask

    task automatic test_drain();
        logic [7:0] v;
        tx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin
                fails++;
                $display("FAIL drain_seq[%0d]: got valid=%b data=%h expected valid=1 data=%h", i, tx_valid, tx_data, 8'(i));
            end
            step();
        end
        tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL drain_empty_valid: got %b expected 0", tx_valid); end
        do_read(2'd1, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL drain_status: got %h expected 01", v); end
        do_push(8'h77);
        tests++; if (tx_data !== 8'h77) begin fails++; $display("FAIL wrap_head: got %h expected 77", tx_data); end
    endtask

    task automatic test_push_pop();
        logic [7:0] v;
        logic [7:0] seq [3];
        seq = '{8'h11, 8'h22, 8'h55};
        tx_ready = 1'b0;
        do_push(8'h11);
        do_push(8'h22);
        do_read(2'd2, v);
        tests++; if (v !== 8'h03) begin fails++; $display("FAIL pp_pre_count: got %h expected 03", v); end
        cs_n = 1'b0; we = 1'b1; addr = 2'd0; wdata = 8'h55; tx_ready = 1'b1;
        step();
        idle();
        tx_ready = 1'b0;
        do_read(2'd2, v);
        tests++; if (v !== 8'h03) begin fails++; $display("FAIL pp_count: got %h expected 03", v); end
        tx_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (tx_valid !== 1'b1 || tx_data !== seq[k]) begin
                fails++;
                $display("FAIL pp_order[%0d]: got valid=%b data=%h expected valid=1 data=%h", k, tx_valid, tx_data, seq[k]);
            end
            step();
        end
        tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL pp_empty: got %b expected 0", tx_valid); end
    endtask

    task automatic test_flush();
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) do_push(8'hA0 + 8'(i));
        do_push(8'hFF);
        tx_ready = 1'b1;
        repeat (DEPTH - 5) step();
        tx_ready = 1'b0;
        do_write(2'd3, 8'hFE);
        do_write(2'd1, 8'hFF);
        do_write(2'd2, 8'hFF);
        do_read(2'd2, v);
        tests++; if (v !== 8'h05) begin fails++; $display("FAIL noeffect_count: got %h expected 05", v); end
        cs_n = 1'b0; we = 1'b1; addr = 2'd3; wdata = 8'h01; tx_ready = 1'b1;
        step();
        idle();
        tx_ready = 1'b0;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL flush_valid: got %b expected 0", tx_valid); end
        do_read(2'd2, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL flush_count: got %h expected 00", v); end
        do_read(2'd1, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL flush_status: got %h expected 01", v); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_push(8'hC1 + 8'(i));
        tx_ready = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL async_valid: got %b expected 0", tx_valid); end
        tests++; if (tx_data !== m_mem[0]) begin fails++; $display("FAIL reset_tx_data: got %h expected %h", tx_data, m_mem[0]); end
        cs_n = 1'b0; we = 1'b0; addr = 2'd2; #1;
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL async_count: got %h expected 00", rdata); end
        idle();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        tx_ready = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL release_valid: got %b expected 0", tx_valid); end
        do_read(2'd2, v);
        tests++; if (v !== 8'h00) begin fails++; $display("FAIL release_count: got %h expected 00", v); end
        do_read(2'd1, v);
        tests++; if (v !== 8'h01) begin fails++; $display("FAIL release_status: got %h expected 01", v); end
    endtask

    task automatic test_random();
        int r;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            tx_ready = ($urandom_range(0, 99) < ((n < 300) ? 25 : 70));
            if (r < 50) begin
                cs_n = 1'b0; we = 1'b1; addr = 2'd0; wdata = 8'($urandom);
            end else if (r < 60) begin
                cs_n = 1'b0; we = 1'b0; addr = 2'd1; wdata = 8'($urandom);
            end else if (r < 70) begin
                cs_n = 1'b0; we = 1'b0; addr = 2'd2; wdata = 8'($urandom);
            end else if (r < 75) begin
                cs_n = 1'b0; we = 1'b0; addr = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3; wdata = 8'($urandom);
            end else if (r < 78) begin
                cs_n = 1'b0; we = 1'b1; addr = 2'd3; wdata = 8'($urandom);
            end else if (r < 82) begin
                cs_n = 1'b0; we = 1'b1; addr = 2'($urandom_range(1, 2)); wdata = 8'($urandom);
            end else begin
                cs_n = 1'b1; we = 1'($urandom); addr = 2'($urandom); wdata = 8'($urandom);
            end
            #1;
            tests++;
            if (rdata !== exp_rdata()) begin
                fails++;
                $display("FAIL rand_rdata[%0d]: got %h expected %h", n, rdata, exp_rdata());
            end
            tests++;
            if (tx_valid !== (m_q.size() != 0)) begin
                fails++;
                $display("FAIL rand_tx_valid[%0d]: got %b expected %b", n, tx_valid, m_q.size() != 0);
            end
            if (m_q.size() != 0) begin
                tests++;
                if (tx_data !== m_q[0]) begin
                    fails++;
                    $display("FAIL rand_tx_data[%0d]: got %h expected %h", n, tx_data, m_q[0]);
                end
            end
            step();
            idle();
        end
        tx_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_overflow();
        test_drain();
        test_push_pop();
        test_flush();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
